// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Build option UART_RX_PARITY_EN adds the PARITY state to the receiver state set.
package uart_pkg;

    localparam int DATA_BITS_C         = 8;
    localparam int CLKS_PER_BIT_115200 = 868;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} rx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input.
// Resets to 1 so that an idle-high line does not show a false edge when reset is released.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-cycle valid / framing-error pulses.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = DATA_BITS_C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_bit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     clk_cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_out_next;
    logic                 armed, armed_next;
    logic                 valid_next, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit, parity_next;
    logic                 perr_next;
`endif

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_bit),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            armed      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            clk_cnt    <= cnt_next;
            bit_idx    <= idx_next;
            shift_reg  <= shift_next;
            armed      <= armed_next;
            data_out   <= data_out_next;
            data_valid <= valid_next;
            frame_err  <= ferr_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_bit <= parity_next;
            parity_err <= perr_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // armed only rises on a high line in IDLE, so a line stuck low never starts a frame
    always_comb begin
        state_next    = state;
        cnt_next      = clk_cnt + 1'b1;
        idx_next      = bit_idx;
        shift_next    = shift_reg;
        armed_next    = armed;
        data_out_next = data_out;
        valid_next    = 1'b0;
        ferr_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_next   = parity_bit;
        perr_next     = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed) begin
                    armed_next = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (clk_cnt == HALF_END) begin
                    cnt_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_END) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    idx_next            = bit_idx + 1'b1;
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt == BIT_END) begin
                    cnt_next    = '0;
                    parity_next = rx_s;
                    state_next  = STOP;
                end
            end
`endif
            STOP: begin
                if (clk_cnt == BIT_END) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (!rx_s) begin
                        ferr_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_reg, parity_bit}) begin
                        perr_next = 1'b1;
`endif
                    end else begin
                        valid_next    = 1'b1;
                        data_out_next = shift_reg;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
